arcade_input_map: RTL

ARCADE_INPUT_MAP -- requirements
Module: arcade_input_map

---
 rtl/arcade_input_map.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/arcade_input_map.sv
// arcade_input_map: merges PS/2 keyboard events and per-player joystick words
// into registered per-player control bytes. It stretches coin pulses and can
// optionally modulate fire with a shared autofire square wave.
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN. When it is undefined there
// is no autofire timebase, af_en is ignored, fire passes straight through and
// bit [7] of each byte reads 0.
module arcade_input_map #(
    parameter int unsigned PLAYERS   = 2,
    parameter logic [15:0] COIN_HOLD = 16'd1800,
    parameter logic [19:0] AF_HALF   = 20'd300000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [10:0]           ps2_key,
    input  logic [16*PLAYERS-1:0] joy_in,
    input  logic [PLAYERS-1:0]    af_en,
    output logic [8*PLAYERS-1:0]  ctrl_out
);

    // Bit positions shared by the raw vector, joystick word and output byte.
    localparam int BIT_R     = 0;
    localparam int BIT_L     = 1;
    localparam int BIT_D     = 2;
    localparam int BIT_U     = 3;
    localparam int BIT_FIRE  = 4;
    localparam int BIT_START = 5;
    localparam int BIT_COIN  = 6;

    // Only players 0 and 1 have keyboard keys, so only two key-state words exist.
    logic [1:0][6:0]         key_q, key_d;
    logic                    toggle_q, toggle_d;
    logic                    key_event;
    logic [PLAYERS-1:0][6:0] raw;
    logic [PLAYERS-1:0]      coin_prev_q, coin_prev_d;
    logic [15:0]             coin_cnt_q [PLAYERS];
    logic [15:0]             coin_cnt_d [PLAYERS];
    logic [PLAYERS-1:0]      coin_out;
    logic [8*PLAYERS-1:0]    ctrl_q, ctrl_d;

    // The extended-code flag is deliberately not decoded, and joystick bits above [6] carry no function.
    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[8], joy_in};

    // A key event is any change of the toggle bit since the previous edge.
    always_comb begin
        toggle_d  = ps2_key[10];
        key_event = (ps2_key[10] != toggle_q);
        // NOTE: key_d takes key_q first, so unmapped codes hold state and no latch is inferred.
        key_d     = key_q;
        if (key_event) begin
            case (ps2_key[7:0])
                8'h75:        key_d[0][BIT_U]     = ps2_key[9];
                8'h72:        key_d[0][BIT_D]     = ps2_key[9];
                8'h6B:        key_d[0][BIT_L]     = ps2_key[9];
                8'h74:        key_d[0][BIT_R]     = ps2_key[9];
                8'h29, 8'h14: key_d[0][BIT_FIRE]  = ps2_key[9];
                8'h16, 8'h05: key_d[0][BIT_START] = ps2_key[9];
                8'h2E:        key_d[0][BIT_COIN]  = ps2_key[9];
                8'h2D:        if (PLAYERS > 1) key_d[1][BIT_U]     = ps2_key[9];
                8'h2B:        if (PLAYERS > 1) key_d[1][BIT_D]     = ps2_key[9];
                8'h23:        if (PLAYERS > 1) key_d[1][BIT_L]     = ps2_key[9];
                8'h34:        if (PLAYERS > 1) key_d[1][BIT_R]     = ps2_key[9];
                8'h1C:        if (PLAYERS > 1) key_d[1][BIT_FIRE]  = ps2_key[9];
                8'h1E, 8'h06: if (PLAYERS > 1) key_d[1][BIT_START] = ps2_key[9];
                8'h36:        if (PLAYERS > 1) key_d[1][BIT_COIN]  = ps2_key[9];
                default:      ;
            endcase
        end
    end

    // Raw per-player controls: keyboard state ORed with the joystick word.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            raw[p] = joy_in[16*p +: 7];
            if (p == 0) begin
                raw[p] = raw[p] | key_q[0];
            end else if (p == 1) begin
                raw[p] = raw[p] | key_q[1];
            end
        end
    end

    // Coin stretcher: a rising edge loads COIN_HOLD, and the countdown runs
    // only after raw coin drops, so the output outlasts the release by
    // COIN_HOLD cycles whether the press was short or long.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            coin_prev_d[p] = raw[p][BIT_COIN];
            coin_out[p]    = raw[p][BIT_COIN] | (coin_cnt_q[p] != 16'd0);
            if (raw[p][BIT_COIN] && !coin_prev_q[p]) begin
                coin_cnt_d[p] = COIN_HOLD;
            end else if (!raw[p][BIT_COIN] && (coin_cnt_q[p] != 16'd0)) begin
                coin_cnt_d[p] = coin_cnt_q[p] - 16'd1;
            end else begin
                coin_cnt_d[p] = coin_cnt_q[p];
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] af_cnt_q, af_cnt_d;
    logic        af_phase_q, af_phase_d;

    // Shared autofire timebase: count 0..AF_HALF-1, toggling phase on each wrap.
    always_comb begin
        if (af_cnt_q == AF_HALF - 20'd1) begin
            af_cnt_d   = 20'd0;
            af_phase_d = ~af_phase_q;
        end else begin
            af_cnt_d   = af_cnt_q + 20'd1;
            af_phase_d = af_phase_q;
        end
    end

    // Autofire timebase register; the phase restarts high out of reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_q   <= 20'd0;
            af_phase_q <= 1'b1;
        end else begin
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
        end
    end
`else
    logic unused_af;
    assign unused_af = ^af_en;
`endif

    // Assemble each output byte from raw controls, stretched coin and autofire.
    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            logic af_active;
            logic fire;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            af_active = af_en[p] & raw[p][BIT_FIRE];
            fire      = af_active ? af_phase_q : raw[p][BIT_FIRE];
`else
            af_active = 1'b0;
            fire      = raw[p][BIT_FIRE];
`endif
            ctrl_d[8*p +: 8] = {af_active, coin_out[p], raw[p][BIT_START], fire,
                                raw[p][BIT_U], raw[p][BIT_D], raw[p][BIT_L], raw[p][BIT_R]};
        end
    end

    // State registers; the toggle register tracks ps2_key[10] even in reset.
    always_ff @(posedge clk_sys) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
        toggle_q <= toggle_d;
        if (reset) begin
            key_q       <= '0;
            coin_prev_q <= '0;
            ctrl_q      <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_cnt_q[p] <= 16'd0;
            end
        end else begin
            key_q       <= key_d;
            coin_prev_q <= coin_prev_d;
            ctrl_q      <= ctrl_d;
            for (int p = 0; p < PLAYERS; p++) begin
                coin_cnt_q[p] <= coin_cnt_d[p];
            end
        end
    end

    assign ctrl_out = ctrl_q;

endmodule
